// File: rtl/packet_ejector_sink.sv
// Local-port flit sink: credit-managed FIFO, drain, head/body/tail parser, stats; EJECTOR_TRACE_EN adds a per-packet trace.
// Latency: pushed flit poppable next cycle; packet_done registered one cycle after the tail pops; credit_out lags occupancy by one cycle.
// Backpressure: credit_out advertises free slots; a flit arriving on a full FIFO with no pop is dropped and flagged.

`ifndef BUFFERSIZE
`define BUFFERSIZE 4
`endif
`ifndef BUFFERSIZE_WIDTH
`define BUFFERSIZE_WIDTH 3
`endif
`ifndef FLIT_DST_WIDTH
`define FLIT_DST_WIDTH 6
`endif
`ifndef FLIT_ID_WIDTH
`define FLIT_ID_WIDTH 8
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif

// Generic synchronous FIFO; arbitrary depth, registered read pointer, no fall-through.
// Latency: write visible at rd_dat the cycle after push.
// Backpressure: caller must not push when full unless popping in the same cycle.
module sync_fifo #(
   parameter int P_WIDTH = 8,
   parameter int P_DEPTH = 4,
   parameter int P_CNT_W = 3
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               push,
   input  logic               pop,
   input  logic [P_WIDTH-1:0] wr_dat,
   output logic [P_WIDTH-1:0] rd_dat,
   output logic [P_CNT_W-1:0] count,
   output logic               full,
   output logic               empty
);
   localparam int PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
   localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(P_DEPTH - 1);
   localparam logic [P_CNT_W-1:0] DEPTH_C  = P_CNT_W'(P_DEPTH);

   logic [P_WIDTH-1:0] mem [P_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + P_CNT_W'(1);
            2'b01:   count <= count - P_CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end

   assign rd_dat = mem[rd_ptr];
   assign full   = (count == DEPTH_C);
   assign empty  = (count == '0);
endmodule

module packet_ejector_sink #(
   parameter int P_LOCAL_ID   = 0,
   parameter int P_LOCAL_PORT = 0,
   parameter int P_DEPTH      = `BUFFERSIZE,
   parameter int P_CNT_WIDTH  = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         data_valid,
   input  logic [`FLIT_WIDTH-1:0]       data_in,
   input  logic                         drain_enable,
   output logic [`BUFFERSIZE_WIDTH-1:0] credit_out,
   output logic                         packet_done,
   output logic [`FLIT_ID_WIDTH-1:0]    packet_done_id,
   output logic [P_CNT_WIDTH-1:0]       packet_flit_count,
   output logic [31:0]                  rx_packet_count,
   output logic [31:0]                  rx_flit_count,
   output logic [3:0]                   err_flags
);
   localparam int W  = `FLIT_WIDTH;
   localparam int DW = `FLIT_DST_WIDTH;
   localparam int IW = `FLIT_ID_WIDTH;
   localparam int BW = `BUFFERSIZE_WIDTH;

   typedef struct packed {
      logic [1:0]    ftype;
      logic [DW-1:0] dst;
      logic [IW-1:0] id;
   } hdr_t;

   localparam int HW = $bits(hdr_t);

   localparam logic [1:0] T_HEAD = 2'b10;
   localparam logic [1:0] T_BODY = 2'b00;
   localparam logic [1:0] T_TAIL = 2'b01;
   localparam logic [1:0] T_ILL  = 2'b11;

   localparam logic [BW-1:0]          DEPTH_C  = BW'(P_DEPTH);
   localparam logic [DW-1:0]          LOCAL_ID = DW'(P_LOCAL_ID);
   localparam logic [P_CNT_WIDTH-1:0] CNT_ONE  = P_CNT_WIDTH'(1);

   if (P_DEPTH < 2 || P_DEPTH > (1 << BW) - 1 || P_LOCAL_PORT < 0) begin : g_bad_cfg
      $error("packet_ejector_sink: illegal P_DEPTH or P_LOCAL_PORT");
   end

   typedef enum logic {S_IDLE, S_IN_PKT} state_t;

   state_t                 state;
   logic [IW-1:0]          cur_id;
   logic [P_CNT_WIDTH-1:0] cnt_q;
   logic [P_CNT_WIDTH-1:0] cnt_inc;

   hdr_t          wr_hdr;
   hdr_t          rd_hdr;
   logic [BW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop_vld;
   logic          push_vld;
   logic          overflow;

   // Only the header fields matter to the sink, so payload bits are not buffered.
   assign wr_hdr   = hdr_t'(data_in[W-1 -: HW]);
   assign pop_vld  = drain_enable & ~fifo_empty;
   assign push_vld = data_valid & (~fifo_full | pop_vld);
   assign overflow = data_valid & fifo_full & ~pop_vld;
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

   sync_fifo #(
      .P_WIDTH (HW),
      .P_DEPTH (P_DEPTH),
      .P_CNT_W (BW)
   ) u_fifo (
      .CLK    (CLK),
      .RST    (RST),
      .push   (push_vld),
      .pop    (pop_vld),
      .wr_dat (wr_hdr),
      .rd_dat (rd_hdr),
      .count  (fifo_count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state             <= S_IDLE;
         cur_id            <= '0;
         cnt_q             <= '0;
         credit_out        <= DEPTH_C;
         packet_done       <= 1'b0;
         packet_done_id    <= '0;
         packet_flit_count <= '0;
         rx_packet_count   <= '0;
         rx_flit_count     <= '0;
         err_flags         <= '0;
      end else begin
         credit_out  <= DEPTH_C - fifo_count;
         packet_done <= 1'b0;
         if (overflow) err_flags[0] <= 1'b1;
         if (pop_vld) begin
            rx_flit_count <= rx_flit_count + 32'd1;
            case (state)
               S_IDLE: begin
                  case (rd_hdr.ftype)
                     T_HEAD: begin
                        cur_id <= rd_hdr.id;
                        cnt_q  <= CNT_ONE;
                        state  <= S_IN_PKT;
                        if (rd_hdr.dst != LOCAL_ID) err_flags[1] <= 1'b1;
                     end
                     T_ILL:   err_flags[3] <= 1'b1;
                     default: err_flags[2] <= 1'b1;
                  endcase
               end
               S_IN_PKT: begin
                  case (rd_hdr.ftype)
                     T_BODY: begin
                        cnt_q <= cnt_inc;
                        if (rd_hdr.id != cur_id) err_flags[2] <= 1'b1;
                     end
                     T_TAIL: begin
                        packet_done       <= 1'b1;
                        packet_done_id    <= cur_id;
                        packet_flit_count <= cnt_inc;
                        rx_packet_count   <= rx_packet_count + 32'd1;
                        state             <= S_IDLE;
                     end
                     // A stray head abandons the open packet and starts tracking the new one.
                     T_HEAD: begin
                        err_flags[2] <= 1'b1;
                        cur_id       <= rd_hdr.id;
                        cnt_q        <= CNT_ONE;
                        if (rd_hdr.dst != LOCAL_ID) err_flags[1] <= 1'b1;
                     end
                     default: err_flags[3] <= 1'b1;
                  endcase
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef EJECTOR_TRACE_EN
   always @(posedge CLK) begin
      if (packet_done)
         $display("%0t ejector node=%0d port=%0d pkt_id=%0d flits=%0d err=%b",
                  $time, P_LOCAL_ID, P_LOCAL_PORT, packet_done_id, packet_flit_count, err_flags);
   end
`endif
endmodule

// File: tb/tb_packet_ejector_sink.sv
// Directed bench for packet_ejector_sink: P_DEPTH=4, P_LOCAL_ID=3, immediate-assertion checks.

`ifndef BUFFERSIZE
`define BUFFERSIZE 4
`endif
`ifndef BUFFERSIZE_WIDTH
`define BUFFERSIZE_WIDTH 3
`endif
`ifndef FLIT_DST_WIDTH
`define FLIT_DST_WIDTH 6
`endif
`ifndef FLIT_ID_WIDTH
`define FLIT_ID_WIDTH 8
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif

module tb_packet_ejector_sink;
   localparam int W  = `FLIT_WIDTH;
   localparam int DW = `FLIT_DST_WIDTH;
   localparam int IW = `FLIT_ID_WIDTH;
   localparam int HW = 2 + DW + IW;

   logic                         CLK = 1'b0;
   logic                         RST = 1'b1;
   logic                         data_valid = 1'b0;
   logic [W-1:0]                 data_in = '0;
   logic                         drain_enable = 1'b0;
   logic [`BUFFERSIZE_WIDTH-1:0] credit_out;
   logic                         packet_done;
   logic [IW-1:0]                packet_done_id;
   logic [7:0]                   packet_flit_count;
   logic [31:0]                  rx_packet_count;
   logic [31:0]                  rx_flit_count;
   logic [3:0]                   err_flags;

   int checks   = 0;
   int failures = 0;
   int done_pulses = 0;

   packet_ejector_sink #(
      .P_LOCAL_ID   (3),
      .P_LOCAL_PORT (1),
      .P_DEPTH      (4),
      .P_CNT_WIDTH  (8)
   ) dut (
      .CLK               (CLK),
      .RST               (RST),
      .data_valid        (data_valid),
      .data_in           (data_in),
      .drain_enable      (drain_enable),
      .credit_out        (credit_out),
      .packet_done       (packet_done),
      .packet_done_id    (packet_done_id),
      .packet_flit_count (packet_flit_count),
      .rx_packet_count   (rx_packet_count),
      .rx_flit_count     (rx_flit_count),
      .err_flags         (err_flags)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (RST) done_pulses = 0;
      else if (packet_done) done_pulses = done_pulses + 1;
   end

   function automatic logic [W-1:0] mk(input logic [1:0] t, input logic [DW-1:0] d, input logic [IW-1:0] i);
      logic [W-1:0] f;
      f = '0;
      f[W-1 -: HW] = {t, d, i};
      return f;
   endfunction

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [W-1:0] f);
      data_valid = 1'b1;
      data_in    = f;
      step();
   endtask

   task automatic do_reset();
      data_valid   = 1'b0;
      drain_enable = 1'b0;
      RST = 1'b1;
      step(2);
      RST = 1'b0;
      step();
   endtask

   initial begin
      // Reset and idle
      do_reset();
      chk("rst_credit", 32'(credit_out), 32'd4);
      chk("rst_done", 32'(packet_done), 32'd0);
      chk("rst_done_id", 32'(packet_done_id), 32'd0);
      chk("rst_flit_cnt", 32'(packet_flit_count), 32'd0);
      chk("rst_rx_pkt", rx_packet_count, 32'd0);
      chk("rst_rx_flit", rx_flit_count, 32'd0);
      chk("rst_err", 32'(err_flags), 32'd0);

      // Five-flit packet, id 5, continuous drain
      drain_enable = 1'b1;
      send(mk(2'b10, 3, 5));
      send(mk(2'b00, 3, 5));
      send(mk(2'b00, 3, 5));
      send(mk(2'b00, 3, 5));
      send(mk(2'b01, 3, 5));
      data_valid = 1'b0;
      step();
      chk("p1_done", 32'(packet_done), 32'd1);
      chk("p1_id", 32'(packet_done_id), 32'd5);
      chk("p1_cnt", 32'(packet_flit_count), 32'd5);
      chk("p1_rx_pkt", rx_packet_count, 32'd1);
      chk("p1_rx_flit", rx_flit_count, 32'd5);
      step();
      chk("p1_pulse_end", 32'(packet_done), 32'd0);
      chk("p1_pulses", 32'(done_pulses), 32'd1);
      chk("p1_err", 32'(err_flags), 32'd0);

      // Fill with drain off; credit lags occupancy by one cycle
      drain_enable = 1'b0;
      step();
      send(mk(2'b10, 3, 7));
      chk("fill_credit_a", 32'(credit_out), 32'd4);
      send(mk(2'b00, 3, 7));
      chk("fill_credit_b", 32'(credit_out), 32'd3);
      send(mk(2'b00, 3, 7));
      chk("fill_credit_c", 32'(credit_out), 32'd2);
      send(mk(2'b01, 3, 7));
      chk("fill_credit_d", 32'(credit_out), 32'd1);
      send(mk(2'b00, 3, 7));
      chk("fill_credit_e", 32'(credit_out), 32'd0);
      chk("ovf_err", 32'(err_flags), 32'd1);
      chk("ovf_rx_flit", rx_flit_count, 32'd5);

      // Push and pop together while full
      drain_enable = 1'b1;
      send(mk(2'b10, 3, 8));
      data_valid = 1'b0;
      chk("pp_credit", 32'(credit_out), 32'd0);
      chk("pp_err", 32'(err_flags), 32'd1);
      step();
      chk("pp_credit2", 32'(credit_out), 32'd0);
      step(2);
      chk("p2_done", 32'(packet_done), 32'd1);
      chk("p2_id", 32'(packet_done_id), 32'd7);
      chk("p2_cnt", 32'(packet_flit_count), 32'd4);
      chk("p2_rx_pkt", rx_packet_count, 32'd2);
      chk("p2_rx_flit", rx_flit_count, 32'd9);
      step();
      chk("p2_pulses", 32'(done_pulses), 32'd2);
      chk("p2_rx_flit_head8", rx_flit_count, 32'd10);

      // Orphan body, then wrong-destination two-flit packet
      do_reset();
      chk("rst2_err", 32'(err_flags), 32'd0);
      chk("rst2_credit", 32'(credit_out), 32'd4);
      drain_enable = 1'b1;
      send(mk(2'b00, 3, 1));
      send(mk(2'b10, 2, 9));
      send(mk(2'b01, 2, 9));
      data_valid = 1'b0;
      step();
      chk("p3_done", 32'(packet_done), 32'd1);
      chk("p3_id", 32'(packet_done_id), 32'd9);
      chk("p3_cnt", 32'(packet_flit_count), 32'd2);
      chk("p3_err", 32'(err_flags), 32'h6);
      chk("p3_rx_flit", rx_flit_count, 32'd3);
      step();
      chk("p3_pulses", 32'(done_pulses), 32'd1);

      // Reset mid-packet, then a clean packet
      do_reset();
      drain_enable = 1'b1;
      send(mk(2'b10, 3, 4));
      send(mk(2'b00, 3, 4));
      send(mk(2'b00, 3, 4));
      data_valid = 1'b0;
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("abort_done", 32'(packet_done), 32'd0);
      chk("abort_credit", 32'(credit_out), 32'd4);
      chk("abort_rx_flit", rx_flit_count, 32'd0);
      step();
      send(mk(2'b10, 3, 6));
      send(mk(2'b01, 3, 6));
      data_valid = 1'b0;
      step();
      chk("p4_done", 32'(packet_done), 32'd1);
      chk("p4_id", 32'(packet_done_id), 32'd6);
      chk("p4_cnt", 32'(packet_flit_count), 32'd2);
      chk("p4_rx_pkt", rx_packet_count, 32'd1);
      chk("p4_rx_flit", rx_flit_count, 32'd2);
      chk("p4_err", 32'(err_flags), 32'd0);

      // Illegal flit type
      send(mk(2'b11, 3, 6));
      data_valid = 1'b0;
      step();
      chk("ill_err", 32'(err_flags), 32'h8);
      chk("ill_pulses", 32'(done_pulses), 32'd1);
      chk("ill_rx_pkt", rx_packet_count, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
